// File: rtl/uart_output_handler.sv
// Serialises one latched response {status, address, data} as a 26-byte ASCII frame
// (ID, 24 uppercase hex digits, terminator) into a UART TX byte interface.
module uart_output_handler #(
  parameter logic [7:0] ID_CHAR   = 8'h53,
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        send_en_i,
  input  logic [31:0] status_i,
  input  logic [31:0] address_i,
  input  logic [31:0] data_i,
  input  logic        tx_busy_i,
  output logic [7:0]  byte_o,
  output logic        byte_write_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_ID,
    SEND_HEX,
    SEND_TERM,
    FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [95:0] hold_q, hold_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        bw_q, bw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        can_issue;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // A byte may only go out when the transmitter is free and we did not strobe last cycle.
  assign can_issue = !tx_busy_i && !bw_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= 8'h00;
      bw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      bw_q    <= bw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    bw_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (send_en_i) begin
          hold_d  = {status_i, address_i, data_i};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SEND_ID;
        end
      end
      SEND_ID: begin
        if (can_issue) begin
          byte_d  = ID_CHAR;
          bw_d    = 1'b1;
          state_d = SEND_HEX;
        end
      end
      SEND_HEX: begin
        if (can_issue) begin
          byte_d = hex_char(hold_q[95:92]);
          bw_d   = 1'b1;
          hold_d = {hold_q[91:0], 4'h0};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            state_d = SEND_TERM;
          end
        end
      end
      SEND_TERM: begin
        if (can_issue) begin
          byte_d  = TERM_CHAR;
          bw_d    = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign byte_o       = byte_q;
  assign byte_write_o = bw_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: doc/uart_output_handler.md
Name: uart_output_handler

Overview:
Transmit-side companion to the UART command parser. It latches one response (status, address, data) and serialises it as an ASCII frame of 26 bytes into the UART transmitter's byte interface:
- ID character.
- 8 hex digits of status, then 8 of address, then 8 of data, each MSB nibble first.
- Terminator.

It sits between the host-interface master and the UART TX core.

Parameters:
ID_CHAR, 8'h53, first byte of every frame ('S').
TERM_CHAR, 8'h0A, last byte of every frame (line feed).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
send_en  input  1  request to send; sampled only in IDLE
status  input  32  response status word, latched on accept
address  input  32  response address word, latched on accept
data  input  32  response data word, latched on accept
tx_busy  input  1  UART TX cannot take a byte while high
byte  output  8  byte to transmit, valid while byte_write=1
byte_write  output  1  one-cycle strobe: transmit byte
busy  output  1  frame in progress
done  output  1  one-cycle pulse after last byte issued

Behaviour:
Reset (rst=0, async):
- state=IDLE; byte=8'h00; byte_write=0; busy=0; done=0.
- 96-bit holding register cleared; nibble counter cleared.
- Any frame in progress is abandoned, with no further bytes after reset releases.

States:
- IDLE, SEND_ID, SEND_HEX, SEND_TERM, FINISH.
- All outputs are registered.

IDLE:
- Rising edge with send_en=1: latch {status,address,data} into the holding register, nibble counter=0, busy<=1, state<=SEND_ID.
- send_en=0: hold.

Byte issue rule (SEND_ID, SEND_HEX, SEND_TERM):
- On an edge where tx_busy=0 and byte_write is currently 0: byte<=character, byte_write<=1, then advance.
- Otherwise byte_write<=0 and no advance.
- byte_write is therefore never high two cycles in a row. Minimum 2 cycles per byte; minimum frame is 26 writes over 52 cycles from accept.
- First byte_write is at the edge after accept (if tx_busy=0).

Characters:
- SEND_ID issues ID_CHAR, then goes to SEND_HEX.
- SEND_HEX issues nibble holding[95:92] and shifts the holding register left by 4. Counter increments.
- After 24 nibbles (counter 23 issued), go to SEND_TERM.
- SEND_TERM issues TERM_CHAR, then goes to FINISH.

Hex encoding (uppercase only):
- n in 0..9 gives 8'h30+n.
- n in 10..15 gives 8'h41+(n-10).

FINISH (one cycle):
- byte_write<=0, done<=1, busy<=0, state<=IDLE.
- done is high for exactly one cycle.
- send_en is ignored on the FINISH edge and accepted from the following edge.

Other rules:
- send_en while busy=1 is ignored and not queued.
- Input words may change after accept without affecting the frame.
- byte holds its last value when byte_write=0.
- tx_busy may stay high indefinitely. The block stalls with no timeout and no byte lost or repeated.

Test Plan:
- Normal frame: status=0x00000001, address=0x10000009, data=0x89ABCDEF, tx_busy=0, one-cycle send_en.
  - Expect exactly 26 byte_write strobes in order: 53, 30×7, 31, 31, 30×6, 39, 38, 39, 41, 42, 43, 44, 45, 46, 0A.
  - Strobes spaced 2 cycles apart; done pulse 1 cycle after the last strobe; busy high from the accept edge to done.
- Encoding edges: status=0x00000000, address=0xFFFFFFFF, data=0x0F0F0F0F.
  - Expect eight 0x30, then eight 0x46, then 30,46 repeated; never lowercase (0x66).
- Backpressure: hold tx_busy=1 for 10 cycles after the 5th strobe, and randomly toggle it elsewhere.
  - Expect no strobe while tx_busy=1, sequence identical to the unstalled run, still 26 strobes.
- Ignore while busy: pulse send_en with different words mid-frame; change the input words after accept.
  - Expect the frame to carry the originally latched values and exactly one done.
- Reset mid-frame: drive rst=0 asynchronously (off clock edge) after the 10th strobe.
  - Expect byte_write=0, busy=0, byte=00 immediately.
  - After release, no strobes until a new send_en; the new frame starts with 0x53.
- Back-to-back: assert send_en continuously.
  - Expect the second frame accepted on the edge after the done cycle and two complete frames with no interleaving.
